// File: rtl/chu_uart_v2_if.sv
// chu_uart_v2_if: FPro slot bus bundle for the chu_uart_v2 core.
//   cs      slot select
//   read    read strobe (reads are side-effect free)
//   write   write strobe
//   addr    word address within the slot (only [2:0] decoded)
//   wr_data write data
//   rd_data combinational read data
// master: the bus side (processor / testbench); slave: the UART core.
interface chu_uart_v2_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_uart_v2.sv
// chu_uart_v2: MMIO UART with baud generator, configurable framing
// (5..8 data bits, none/even/odd parity, 1 or 2 stop bits), TX/RX FIFOs,
// sticky RX error flags, fill levels and a registered level interrupt.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    slot bus (chu_uart_v2_if.slave)
//   tx     serial output, idle high, registered
//   rx     serial input, asynchronous to clk
//   irq    registered level interrupt
// Register map (addr[2:0]):
//   0 R  status {frame_err, parity_err, overrun, 0, tx_idle, tx_full, rx_empty, rx_head}
//   1 RW divisor          2 R {tx_count, rx_count} / W push TX byte
//   3 W  pop RX byte      4 RW ctrl               5 W clear error flags (bits 14:12)

// Synchronous first-word-fall-through byte FIFO with occupancy counter.
module chu_uart_v2_fifo #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // A push into a full FIFO still succeeds when a pop frees a slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module chu_uart_v2 #(
  parameter int FIFO_DEPTH_BIT = 8,
  parameter int DVSR_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  chu_uart_v2_if.slave       bus,
  output logic               tx,
  input  logic               rx,
  output logic               irq
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic              wr_en;
  logic [2:0]        sel;
  logic [DVSR_W-1:0] dvsr_reg;
  logic [DVSR_W-1:0] baud_cnt;
  logic              tick;
  logic [6:0]        ctrl_reg;
  logic              frame_err, parity_err, overrun;
  logic              ferr_set, perr_set, ovr_set;
  logic [2:0]        err_clr;
  logic              unused_bits;

  logic              rx_s1, rx_sync;
  state_t            rx_state, rx_state_next;
  logic [3:0]        rx_s, rx_s_next;
  logic [2:0]        rx_n, rx_n_next;
  logic [7:0]        rx_b, rx_b_next;
  logic [3:0]        rx_cfg, rx_cfg_next;
  logic [2:0]        rx_last;
  logic              rx_par_en, rx_par_exp;
  logic              rx_push, rx_pop;
  logic [7:0]        rx_fifo_data;
  logic              rx_empty, rx_full;
  logic [FIFO_DEPTH_BIT:0] rx_count;

  state_t            tx_state, tx_state_next;
  logic [3:0]        tx_s, tx_s_next;
  logic [2:0]        tx_n, tx_n_next;
  logic [7:0]        tx_b, tx_b_next;
  logic [4:0]        tx_cfg, tx_cfg_next;
  logic              tx_par, tx_par_next;
  logic              tx_next;
  logic [2:0]        tx_last;
  logic [7:0]        tx_masked;
  logic              tx_push, tx_pop;
  logic [7:0]        tx_fifo_data;
  logic              tx_empty, tx_full, tx_idle;
  logic [FIFO_DEPTH_BIT:0] tx_count;

  assign unused_bits = &{1'b0, bus.read, bus.addr[4:3], bus.wr_data};

  assign wr_en   = bus.write && bus.cs;
  assign sel     = bus.addr[2:0];
  assign tx_push = wr_en && (sel == 3'd2);
  assign rx_pop  = wr_en && (sel == 3'd3);
  assign err_clr = (wr_en && (sel == 3'd5)) ? bus.wr_data[14:12] : 3'b000;

  // Divisor and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr_reg <= '0;
      ctrl_reg <= '0;
    end else if (wr_en) begin
      if (sel == 3'd1) dvsr_reg <= bus.wr_data[DVSR_W-1:0];
      if (sel == 3'd4) ctrl_reg <= bus.wr_data[6:0];
    end
  end

  // Baud generator: 0..dvsr, so one tick every dvsr+1 clocks (16 ticks per bit).
  assign tick = (baud_cnt == dvsr_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          baud_cnt <= '0;
    else if (wr_en && (sel == 3'd1))    baud_cnt <= '0;
    else if (tick)                      baud_cnt <= '0;
    else                                baud_cnt <= baud_cnt + 1'b1;
  end

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
    end
  end

  chu_uart_v2_fifo #(.AW(FIFO_DEPTH_BIT)) rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .wdata(rx_b_next),
    .rdata(rx_fifo_data), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  chu_uart_v2_fifo #(.AW(FIFO_DEPTH_BIT)) tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .wdata(bus.wr_data[7:0]),
    .rdata(tx_fifo_data), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  // Data-bit count field 00..11 maps to 8..5 bits, i.e. last index 7..4.
  assign rx_last    = 3'd7 - {1'b0, rx_cfg[1:0]};
  assign rx_par_en  = rx_cfg[3] ^ rx_cfg[2];
  assign rx_par_exp = (^rx_b) ^ rx_cfg[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_cfg   <= '0;
    end else begin
      rx_state <= rx_state_next;
      rx_s     <= rx_s_next;
      rx_n     <= rx_n_next;
      rx_b     <= rx_b_next;
      rx_cfg   <= rx_cfg_next;
    end
  end

  // RX framing: start bit re-checked mid-bit (tick 7) to reject glitches,
  // then every later sample lands 16 ticks apart, near each bit centre.
  always_comb begin
    rx_state_next = rx_state;
    rx_s_next     = rx_s;
    rx_n_next     = rx_n;
    rx_b_next     = rx_b;
    rx_cfg_next   = rx_cfg;
    rx_push       = 1'b0;
    perr_set      = 1'b0;
    ferr_set      = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_sync) begin
          rx_state_next = START;
          rx_s_next     = '0;
          rx_b_next     = '0;
          rx_cfg_next   = ctrl_reg[3:0];
        end
      end
      START: begin
        if (tick) begin
          if (rx_s == 4'd7) begin
            rx_s_next = '0;
            rx_n_next = '0;
            rx_state_next = rx_sync ? IDLE : DATA;
          end else begin
            rx_s_next = rx_s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rx_s == 4'd15) begin
            rx_s_next       = '0;
            rx_b_next[rx_n] = rx_sync;
            if (rx_n == rx_last) rx_state_next = rx_par_en ? PARITY : STOP;
            else                 rx_n_next = rx_n + 3'd1;
          end else begin
            rx_s_next = rx_s + 4'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (rx_s == 4'd15) begin
            rx_s_next     = '0;
            perr_set      = (rx_sync != rx_par_exp);
            rx_state_next = STOP;
          end else begin
            rx_s_next = rx_s + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s == 4'd15) begin
            ferr_set      = !rx_sync;
            rx_push       = 1'b1;
            rx_state_next = IDLE;
          end else begin
            rx_s_next = rx_s + 4'd1;
          end
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  // A byte is lost only when no slot is freed by a simultaneous pop.
  assign ovr_set = rx_push && rx_full && !rx_pop;

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ferr_set)        frame_err  <= 1'b1;
      else if (err_clr[2]) frame_err  <= 1'b0;
      if (perr_set)        parity_err <= 1'b1;
      else if (err_clr[1]) parity_err <= 1'b0;
      if (ovr_set)         overrun    <= 1'b1;
      else if (err_clr[0]) overrun    <= 1'b0;
    end
  end

  assign tx_last   = 3'd7 - {1'b0, tx_cfg[1:0]};
  assign tx_masked = tx_fifo_data & (8'hFF >> ctrl_reg[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_cfg   <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_s     <= tx_s_next;
      tx_n     <= tx_n_next;
      tx_b     <= tx_b_next;
      tx_cfg   <= tx_cfg_next;
      tx_par   <= tx_par_next;
      tx       <= tx_next;
    end
  end

  // TX framing: the byte shifts right so tx_b[0] is always the current bit;
  // in STOP, tx_n doubles as "first stop bit done" for two-stop-bit frames.
  always_comb begin
    tx_state_next = tx_state;
    tx_s_next     = tx_s;
    tx_n_next     = tx_n;
    tx_b_next     = tx_b;
    tx_cfg_next   = tx_cfg;
    tx_par_next   = tx_par;
    tx_next       = tx;
    tx_pop        = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_next = 1'b1;
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_b_next     = tx_masked;
          tx_cfg_next   = ctrl_reg[4:0];
          tx_par_next   = (^tx_masked) ^ ctrl_reg[3];
          tx_s_next     = '0;
          tx_next       = 1'b0;
          tx_state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (tx_s == 4'd15) begin
            tx_s_next     = '0;
            tx_n_next     = '0;
            tx_next       = tx_b[0];
            tx_state_next = DATA;
          end else begin
            tx_s_next = tx_s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tx_s == 4'd15) begin
            tx_s_next = '0;
            tx_b_next = {1'b0, tx_b[7:1]};
            if (tx_n == tx_last) begin
              tx_n_next = '0;
              if (tx_cfg[3] ^ tx_cfg[2]) begin
                tx_next       = tx_par;
                tx_state_next = PARITY;
              end else begin
                tx_next       = 1'b1;
                tx_state_next = STOP;
              end
            end else begin
              tx_n_next = tx_n + 3'd1;
              tx_next   = tx_b[1];
            end
          end else begin
            tx_s_next = tx_s + 4'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (tx_s == 4'd15) begin
            tx_s_next     = '0;
            tx_n_next     = '0;
            tx_next       = 1'b1;
            tx_state_next = STOP;
          end else begin
            tx_s_next = tx_s + 4'd1;
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (tx_s == 4'd15) begin
            tx_s_next = '0;
            if (tx_cfg[4] && (tx_n == 3'd0)) tx_n_next = 3'd1;
            else                             tx_state_next = IDLE;
          end else begin
            tx_s_next = tx_s + 4'd1;
          end
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  assign tx_idle = tx_empty && (tx_state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (ctrl_reg[5] && !rx_empty) || (ctrl_reg[6] && tx_empty) ||
                      (ctrl_reg[5] && (frame_err || parity_err || overrun));
  end

  always_comb begin
    bus.rd_data = 32'h0;
    case (sel)
      3'd0: bus.rd_data = {17'b0, frame_err, parity_err, overrun, 1'b0, tx_idle, tx_full,
                           rx_empty, (rx_empty ? 8'h00 : rx_fifo_data)};
      3'd1: bus.rd_data = 32'(dvsr_reg);
      3'd2: bus.rd_data = {16'(tx_count), 16'(rx_count)};
      3'd4: bus.rd_data = {25'b0, ctrl_reg};
      default: bus.rd_data = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_chu_uart_v2.sv
// tb_chu_uart_v2: directed self-checking bench for chu_uart_v2
// (FIFO_DEPTH_BIT=2, divisor 3 -> 64 clocks per serial bit).
module tb_chu_uart_v2;
  logic clk;
  logic reset;
  logic tx;
  logic rx_line;
  logic rx_drive;
  logic loopback;
  logic irq;
  int   checks;
  int   failures;

  chu_uart_v2_if bus_if ();

  chu_uart_v2 #(.FIFO_DEPTH_BIT(2), .DVSR_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .tx(tx), .rx(rx_line), .irq(irq)
  );

  assign rx_line = loopback ? tx : rx_drive;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.write = 1'b1; bus_if.addr = a; bus_if.wr_data = d;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.read = 1'b1; bus_if.addr = a;
    #1 d = bus_if.rd_data;
    bus_if.cs = 1'b0; bus_if.read = 1'b0;
  endtask

  // Drive one serial frame on rx: 64 clocks per bit. A zero stop bit is
  // released after 48 clocks so the line is idle again before any re-arm.
  task automatic applyStimulus(input logic [7:0] data, input int nbits, input logic [1:0] pmode,
                               input logic flip, input logic stop_val);
    logic par;
    par = 1'b0;
    @(negedge clk);
    rx_drive = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_drive = data[i];
      par = par ^ data[i];
      repeat (64) @(negedge clk);
    end
    if (pmode == 2'b01 || pmode == 2'b10) begin
      if (pmode == 2'b10) par = ~par;
      if (flip) par = ~par;
      rx_drive = par;
      repeat (64) @(negedge clk);
    end
    rx_drive = stop_val;
    if (!stop_val) begin
      repeat (48) @(negedge clk);
      rx_drive = 1'b1;
      repeat (16) @(negedge clk);
    end else begin
      repeat (64) @(negedge clk);
    end
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  tx_exp;
    checks = 0; failures = 0;
    reset = 1'b1; rx_drive = 1'b1; loopback = 1'b0;
    bus_if.cs = 1'b0; bus_if.read = 1'b0; bus_if.write = 1'b0;
    bus_if.addr = '0; bus_if.wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // Reset state
    bus_read(5'd0, d); checkOutput("reset_status", d, 32'h0000_0500);
    bus_read(5'd2, d); checkOutput("reset_counts", d, 32'h0);

    // Plain 8N1 transmit of 0xA5
    bus_write(5'd1, 32'd3);
    bus_write(5'd4, 32'h0);
    bus_read(5'd1, d); checkOutput("dvsr_rb", d, 32'd3);
    bus_write(5'd2, 32'h0000_00A5);
    for (int i = 0; i < 100 && tx; i++) @(negedge clk);
    checkOutput("tx_start_seen", 32'(tx), 32'd0);
    tx_exp = {1'b1, 8'hA5, 1'b0};
    repeat (40) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("tx_bit%0d", k), 32'(tx), 32'(tx_exp[k]));
      if (k < 9) repeat (64) @(negedge clk);
    end
    repeat (13) @(negedge clk);
    bus_read(5'd0, d); checkOutput("tx_busy_630", 32'(d[10]), 32'd0);
    repeat (14) @(negedge clk);
    bus_read(5'd0, d); checkOutput("tx_idle_645", 32'(d[10]), 32'd1);

    // Loopback 7E1, then a bad-parity frame, then clear the flag
    bus_write(5'd4, 32'h05);
    bus_read(5'd4, d); checkOutput("ctrl_rb", d, 32'h05);
    loopback = 1'b1;
    bus_write(5'd2, 32'h55);
    d = 32'h0;
    for (int i = 0; i < 2000; i++) begin
      bus_read(5'd0, d);
      if (d[10]) break;
    end
    checkOutput("loop_done", 32'(d[10]), 32'd1);
    checkOutput("loop_status", d, 32'h0000_0455);
    loopback = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(8'h13, 7, 2'b01, 1'b1, 1'b1);
    bus_read(5'd0, d); checkOutput("perr_status", d, 32'h0000_2455);
    bus_read(5'd2, d); checkOutput("perr_count", d, 32'h0000_0002);
    bus_write(5'd5, 32'h2000);
    bus_read(5'd0, d); checkOutput("perr_clear", d, 32'h0000_0455);
    bus_write(5'd3, 32'h0);
    bus_read(5'd0, d); checkOutput("pop_head2", d, 32'h0000_0413);
    bus_write(5'd3, 32'h0);
    bus_read(5'd0, d); checkOutput("pop_empty", d, 32'h0000_0500);

    // Glitch rejection and framing error
    bus_write(5'd4, 32'h0);
    @(negedge clk); rx_drive = 1'b0;
    repeat (12) @(negedge clk); rx_drive = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(5'd2, d); checkOutput("glitch_count", d, 32'h0);
    applyStimulus(8'hC3, 8, 2'b00, 1'b0, 1'b0);
    bus_read(5'd0, d); checkOutput("ferr_status", d, 32'h0000_44C3);

    // Overrun with a 4-deep RX FIFO
    bus_write(5'd3, 32'h0);
    bus_write(5'd5, 32'h7000);
    bus_read(5'd0, d); checkOutput("pre_ovr_status", d, 32'h0000_0500);
    applyStimulus(8'h11, 8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h22, 8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h33, 8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h44, 8, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h55, 8, 2'b00, 1'b0, 1'b1);
    bus_read(5'd2, d); checkOutput("ovr_count", d, 32'h0000_0004);
    bus_read(5'd0, d); checkOutput("ovr_status", d, 32'h0000_1411);
    bus_write(5'd3, 32'h0);
    bus_read(5'd0, d); checkOutput("ovr_pop1", d, 32'h0000_1422);
    bus_write(5'd3, 32'h0);
    bus_read(5'd0, d); checkOutput("ovr_pop2", d, 32'h0000_1433);
    bus_write(5'd3, 32'h0);
    bus_read(5'd0, d); checkOutput("ovr_pop3", d, 32'h0000_1444);
    bus_write(5'd3, 32'h0);
    bus_read(5'd0, d); checkOutput("ovr_pop4", d, 32'h0000_1500);
    bus_write(5'd3, 32'h0);
    bus_read(5'd2, d); checkOutput("ovr_pop5_count", d, 32'h0);

    // Interrupt sources
    bus_write(5'd5, 32'h7000);
    bus_write(5'd4, 32'h60);
    repeat (2) @(negedge clk);
    checkOutput("irq_tx_empty", 32'(irq), 32'd1);
    for (int i = 0; i < 5; i++) bus_write(5'd2, 32'(8'h80 + i));
    bus_read(5'd0, d); checkOutput("tx_full_status", d, 32'h0000_0300);
    bus_read(5'd2, d); checkOutput("tx_full_count", d, 32'h0004_0000);
    bus_write(5'd4, 32'h20);
    repeat (2) @(negedge clk);
    checkOutput("irq_off", 32'(irq), 32'd0);
    applyStimulus(8'h3C, 8, 2'b00, 1'b0, 1'b1);
    checkOutput("irq_rx", 32'(irq), 32'd1);
    bus_read(5'd0, d); checkOutput("irq_rx_head", d[8:0], 32'h03C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
